// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader, the write side of the instruction
// memory that the CPU fetch path reads.
//
// Input stream, little-endian throughout:
//   - 4 header bytes holding the word count N.
//   - 4*N data bytes.
//   - With IMEM_LOADER_CSUM_EN defined, one trailing checksum byte, which is
//     the XOR of all data bytes.
// Words are written to IMEM word addresses 0..N-1. The processor is held in
// reset (cpu_rst_x=0) until the image has loaded.
//
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing checksum byte check).
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   rx_valid   byte available on rx_data
//   rx_data    stream byte
//   rx_ready   loader accepts a byte (transfer on rx_valid && rx_ready)
//   reload     single-cycle pulse, restarts loading from DONE or ERR
//   mem_we     IMEM write strobe, one cycle per word
//   mem_addr   IMEM word address
//   mem_wdata  IMEM write data
//   cpu_rst_x  active-low processor reset, released once the load completes
//   done       image loaded successfully
//   err        sticky error flag (oversize image or checksum mismatch)
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_x,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] S_HDR  = 3'd0;
   localparam logic [2:0] S_DATA = 3'd1;
   localparam logic [2:0] S_CSUM = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   // Capacity in words, held at 64 bits so the full 32-bit N compares cleanly.
   localparam logic [63:0] DEPTH = 64'd1 << ADDR_W;

   logic [2:0]    state;
   logic [1:0]    byte_cnt;
   // The three previously accepted bytes of the current header or word.
   // The incoming byte supplies the top byte of the completed value.
   logic [23:0]   shreg;
   // Both counters are one bit wider than ADDR_W, so N == DEPTH is representable.
   logic [ADDR_W:0] n_words;
   logic [ADDR_W:0] word_idx;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]    csum;
`endif

   logic          accept;
   logic [31:0]   byte_word;
   logic [ADDR_W:0] idx_inc;

   always_comb begin
      accept    = rx_valid & rx_ready;
      byte_word = {rx_data, shreg};
      idx_inc   = word_idx + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_HDR;
         byte_cnt  <= '0;
         shreg     <= '0;
         n_words   <= '0;
         word_idx  <= '0;
         rx_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst_x <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum      <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_HDR: begin
               rx_ready <= 1'b1;
               if (accept) begin
                  shreg    <= byte_word[31:8];
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) begin
                     if ({32'd0, byte_word} > DEPTH) begin
                        state    <= S_ERR;
                        rx_ready <= 1'b0;
                     end else if (byte_word == 32'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state    <= S_CSUM;
`else
                        state    <= S_DONE;
                        rx_ready <= 1'b0;
`endif
                     end else begin
                        state    <= S_DATA;
                        n_words  <= byte_word[ADDR_W:0];
                        word_idx <= '0;
                     end
                  end
               end
            end

            S_DATA: begin
               // Ready stays high through the write cycle, so a byte arriving
               // back-to-back starts the next word.
               rx_ready <= 1'b1;
               if (accept) begin
                  shreg    <= byte_word[31:8];
                  byte_cnt <= byte_cnt + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                  csum     <= csum ^ rx_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_idx[ADDR_W-1:0];
                     mem_wdata <= byte_word;
                     word_idx  <= idx_inc;
                     if (idx_inc == n_words) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state    <= S_CSUM;
`else
                        state    <= S_DONE;
                        rx_ready <= 1'b0;
`endif
                     end
                  end
               end
            end

            S_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
               rx_ready <= 1'b1;
               if (accept) begin
                  rx_ready <= 1'b0;
                  state    <= (rx_data == csum) ? S_DONE : S_ERR;
               end
`else
               // Unreachable when the checksum stage is not built.
               rx_ready <= 1'b0;
               state    <= S_ERR;
`endif
            end

            S_DONE, S_ERR: begin
               rx_ready  <= 1'b0;
               done      <= (state == S_DONE);
               err       <= (state == S_ERR);
               cpu_rst_x <= (state == S_DONE);
               if (reload) begin
                  state     <= S_HDR;
                  rx_ready  <= 1'b1;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  cpu_rst_x <= 1'b0;
                  byte_cnt  <= '0;
                  n_words   <= '0;
                  word_idx  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                  csum      <= '0;
`endif
               end
            end

            default: begin
               rx_ready <= 1'b0;
               state    <= S_ERR;
            end
         endcase
      end
   end

endmodule
